// File: rtl/fp_sign_align_pkg.sv
// fp_sign_align_pkg
//   Shared constants and helpers for the float sign-alignment stage and the
//   mismatch detector that reads its output.
//   - FP_N / FP_SIGN_BIT : float word width and sign bit position
//   - SIGN_MATCH / SIGN_OPPOSE : mode encodings
//   - FP_ONE : +1.0f, handy for benches
//   - occ_e : output buffer occupancy
//   - sign_mismatch() : the single sign-XOR definition used on both ends
package fp_sign_align_pkg;

  localparam int FP_N        = 32;
  localparam int FP_SIGN_BIT = FP_N - 1;

  localparam logic SIGN_MATCH  = 1'b0;
  localparam logic SIGN_OPPOSE = 1'b1;

  localparam logic [31:0] FP_ONE = 32'h3F80_0000;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // The mismatch detector downstream uses this same function, so the
  // producer and the checker can never disagree on what "mismatch" means.
  function automatic logic sign_mismatch(input logic sign_a, input logic sign_b);
    return sign_a ^ sign_b;
  endfunction

endpackage

// File: rtl/fp_sign_align_if.sv
// fp_sign_align_if
//   Streaming bus of the sign-alignment stage.
//   Input side : in_valid/in_ready handshake carrying in_ref, in_val, in_mode
//   Output side: out_valid/out_ready handshake carrying out_data, out_flipped
//   modport master : the producer/consumer environment around the stage
//   modport slave  : the stage itself
interface fp_sign_align_if
  import fp_sign_align_pkg::*;
#(
  parameter int N = FP_N
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_ref;
  logic [N-1:0] in_val;
  logic         in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_flipped;

  modport master (
    output in_valid, in_ref, in_val, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_flipped
  );

  modport slave (
    input  in_valid, in_ref, in_val, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_flipped
  );

endinterface

// File: rtl/fp_sign_force.sv
// fp_sign_force
//   Combinational sign forcing of one float against a reference.
//   ref_word : reference float (only its sign is used)
//   val_word : float to align
//   mode     : SIGN_MATCH = take the reference sign, SIGN_OPPOSE = take its inverse
//   aligned  : val_word with the sign bit forced, all other bits untouched
//   flip     : 1 when the forced sign differs from val_word's own sign
module fp_sign_force
  import fp_sign_align_pkg::*;
#(
  parameter int N = FP_N
) (
  input  logic [N-1:0] ref_word,
  input  logic [N-1:0] val_word,
  input  logic         mode,
  output logic [N-1:0] aligned,
  output logic         flip
);

  logic mismatch;
  logic unused_ref_bits;

  assign unused_ref_bits = ^ref_word[N-2:0];

  // A flip is needed when the current sign relation differs from the one
  // the mode asks for. Zero, denormals, Inf and NaN go through unchanged
  // apart from the sign bit.
  always_comb begin
    mismatch = sign_mismatch(ref_word[N-1], val_word[N-1]);
    flip     = mismatch ^ (mode == SIGN_OPPOSE);
    aligned  = {val_word[N-1] ^ flip, val_word[N-2:0]};
  end

endmodule

// File: rtl/fp_sign_align.sv
// fp_sign_align
//   Streaming stage that forces the sign of each float to match or oppose a
//   reference sign, buffers the result in a 2-entry FIFO and counts flips.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   clr        : synchronous clear of flip_count (wins over an increment)
//   bus        : slave side of fp_sign_align_if (input pair / aligned output)
//   flip_count : saturating count of accepted pairs whose sign was flipped
module fp_sign_align
  import fp_sign_align_pkg::*;
#(
  parameter int N  = FP_N,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  fp_sign_align_if.slave      bus,
  output logic [CW-1:0]       flip_count
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  occ_e         occ;
  logic [N-1:0] head_data;
  logic         head_flip;
  logic [N-1:0] spare_data;
  logic         spare_flip;

  logic [N-1:0] new_data;
  logic         new_flip;
  logic         push;
  logic         pop;

  fp_sign_force #(.N(N)) u_force (
    .ref_word (bus.in_ref),
    .val_word (bus.in_val),
    .mode     (bus.in_mode),
    .aligned  (new_data),
    .flip     (new_flip)
  );

  // Ready depends only on registered occupancy (and rst), never on out_ready.
  assign bus.in_ready    = (occ != OCC_FULL) && !rst;
  assign bus.out_valid   = (occ != OCC_EMPTY);
  assign bus.out_data    = head_data;
  assign bus.out_flipped = head_flip;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Head register always holds the oldest entry; the spare register only
  // fills when a push arrives while the head is occupied and not leaving.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ        <= OCC_EMPTY;
      head_data  <= '0;
      head_flip  <= 1'b0;
      spare_data <= '0;
      spare_flip <= 1'b0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (push) begin
            head_data <= new_data;
            head_flip <= new_flip;
            occ       <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            head_data <= new_data;
            head_flip <= new_flip;
          end else if (push) begin
            spare_data <= new_data;
            spare_flip <= new_flip;
            occ        <= OCC_FULL;
          end else if (pop) begin
            occ <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            head_data <= spare_data;
            head_flip <= spare_flip;
            occ       <= OCC_ONE;
          end
        end
        default: occ <= OCC_EMPTY;
      endcase
    end
  end

  // Flip counter: clr beats a same-cycle increment; the count sticks at max.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      flip_count <= '0;
    end else if (push && new_flip && (flip_count != CNT_MAX)) begin
      flip_count <= flip_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_sign_align.sv
// tb_fp_sign_align
//   Self-checking bench for fp_sign_align (built with CW=4 so saturation is
//   reachable). A vector table checks the transform with fixed expectations,
//   hand-written sequences cover backpressure, saturation/clear and reset
//   mid-stream, and a scoreboard checks every output transfer and the flip
//   count against an independent model.
module tb_fp_sign_align;
  import fp_sign_align_pkg::*;

  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic [CW-1:0] flip_count;

  always #5 clk = ~clk;

  fp_sign_align_if #(.N(32)) bus ();

  fp_sign_align #(.N(32), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .bus        (bus),
    .flip_count (flip_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        flip;
  } exp_t;

  exp_t sb_q[$];
  int   model_cnt = 0;

  typedef struct {
    logic [31:0] r;
    logic [31:0] v;
    logic        m;
    logic [31:0] exp_data;
    logic        exp_flip;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] r, input logic [31:0] v,
                               input logic m, input logic valid);
    bus.in_ref   = r;
    bus.in_val   = v;
    bus.in_mode  = m;
    bus.in_valid = valid;
  endtask

  // Scoreboard and flip-count model, evaluated mid-cycle so every handshake
  // seen here is the one the next rising edge will act on.
  always @(negedge clk) begin
    exp_t e;
    logic exp_sign;
    logic pushing;
    if (rst !== 1'b0) begin
      sb_q.delete();
      model_cnt = 0;
    end else begin
      checkOutput("flip_count_model", 32'(flip_count), 32'(model_cnt));
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL unexpected_output: got 0x%08h, want no output", bus.out_data);
        end else begin
          e = sb_q.pop_front();
          checkOutput("sb_data", bus.out_data, e.data);
          checkOutput("sb_flip", 32'(bus.out_flipped), 32'(e.flip));
        end
      end
      pushing = bus.in_valid && bus.in_ready;
      e = '0;
      if (pushing) begin
        exp_sign = (bus.in_mode == SIGN_MATCH) ? bus.in_ref[31] : ~bus.in_ref[31];
        e.data   = {exp_sign, bus.in_val[30:0]};
        e.flip   = (exp_sign != bus.in_val[31]);
        sb_q.push_back(e);
      end
      if (clr) model_cnt = 0;
      else if (pushing && e.flip && model_cnt < CNT_MAX) model_cnt++;
    end
  end

  initial begin
    int waited;

    vecs[0] = '{FP_ONE,       32'hBF80_0000, SIGN_MATCH,  32'h3F80_0000, 1'b1, 1};
    vecs[1] = '{32'h4000_0000, 32'hC000_0000, SIGN_OPPOSE, 32'hC000_0000, 1'b0, 1};
    vecs[2] = '{32'h4000_0000, 32'h4000_0000, SIGN_OPPOSE, 32'hC000_0000, 1'b1, 2};
    vecs[3] = '{32'hBF80_0000, 32'h7FC0_0000, SIGN_MATCH,  32'hFFC0_0000, 1'b1, 3};
    vecs[4] = '{32'h8000_0000, 32'h0000_0000, SIGN_MATCH,  32'h8000_0000, 1'b1, 4};
    vecs[5] = '{32'h0000_0000, 32'h8000_0000, SIGN_OPPOSE, 32'h8000_0000, 1'b0, 4};
    vecs[6] = '{32'h7F80_0000, 32'hFF80_0000, SIGN_MATCH,  32'h7F80_0000, 1'b1, 5};
    vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0001, SIGN_MATCH,  32'h8000_0001, 1'b1, 6};

    applyStimulus(32'h0, 32'h0, SIGN_MATCH, 1'b0);
    bus.out_ready = 1'b0;

    // Reset state
    step();
    checkOutput("in_ready_during_rst", 32'(bus.in_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    checkOutput("in_ready_after_rst", 32'(bus.in_ready), 32'd1);
    checkOutput("out_valid_rst", 32'(bus.out_valid), 32'd0);
    checkOutput("out_data_rst", bus.out_data, 32'h0);
    checkOutput("out_flipped_rst", 32'(bus.out_flipped), 32'd0);
    checkOutput("flip_count_rst", 32'(flip_count), 32'd0);

    // Table-driven transform checks, one pair at a time
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].r, vecs[i].v, vecs[i].m, 1'b1);
      step();
      bus.in_valid = 1'b0;
      waited = 0;
      while (!bus.out_valid && waited < 10) begin
        step();
        waited++;
      end
      checkOutput($sformatf("vec%0d_latency", i), 32'(waited), 32'd0);
      checkOutput($sformatf("vec%0d_data", i), bus.out_data, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d_flip", i), 32'(bus.out_flipped), 32'(vecs[i].exp_flip));
      checkOutput($sformatf("vec%0d_count", i), 32'(flip_count), 32'(vecs[i].exp_cnt));
      step();
    end

    // Backpressure: three back-to-back pairs with the output stalled
    bus.out_ready = 1'b0;
    applyStimulus(FP_ONE, 32'h4120_0000, SIGN_OPPOSE, 1'b1);
    step();
    checkOutput("bp_ready_after_1", 32'(bus.in_ready), 32'd1);
    applyStimulus(32'hC000_0000, 32'h42C8_0000, SIGN_MATCH, 1'b1);
    step();
    checkOutput("bp_ready_after_2", 32'(bus.in_ready), 32'd0);
    checkOutput("bp_head_a", bus.out_data, 32'hC120_0000);
    applyStimulus(32'h0000_0000, 32'h8000_0001, SIGN_MATCH, 1'b1);
    step();
    checkOutput("bp_third_held", 32'(bus.in_ready), 32'd0);
    checkOutput("bp_stable", bus.out_data, 32'hC120_0000);
    checkOutput("bp_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    step();
    checkOutput("bp_head_b", bus.out_data, 32'hC2C8_0000);
    step();
    bus.in_valid = 1'b0;
    checkOutput("bp_head_c", bus.out_data, 32'h0000_0001);
    step();
    checkOutput("bp_empty", 32'(bus.out_valid), 32'd0);

    // Saturation: 20 flipping pairs at full rate
    applyStimulus(FP_ONE, 32'hBF80_0000, SIGN_MATCH, 1'b1);
    repeat (20) step();
    bus.in_valid = 1'b0;
    checkOutput("sat_count", 32'(flip_count), 32'(CNT_MAX));
    step();

    // clr together with a flipping acceptance
    applyStimulus(FP_ONE, 32'hBF80_0000, SIGN_MATCH, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("clr_priority", 32'(flip_count), 32'd0);
    checkOutput("clr_keeps_fifo", bus.out_data, 32'h3F80_0000);
    step();
    applyStimulus(FP_ONE, 32'hBF80_0000, SIGN_MATCH, 1'b1);
    step();
    bus.in_valid = 1'b0;
    checkOutput("count_after_clr", 32'(flip_count), 32'd1);
    step();

    // Reset with two entries buffered
    bus.out_ready = 1'b0;
    applyStimulus(32'h4000_0000, 32'h4040_0000, SIGN_OPPOSE, 1'b1);
    step();
    applyStimulus(32'h8000_0000, 32'h4080_0000, SIGN_MATCH, 1'b1);
    step();
    bus.in_valid = 1'b0;
    checkOutput("mid_full", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    step();
    checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid_rst_count", 32'(flip_count), 32'd0);
    checkOutput("mid_rst_data", bus.out_data, 32'h0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("no_stale_after_rst", 32'(bus.out_valid), 32'd0);
    end

    waited = 0;
    while (sb_q.size() > 0 && waited < 20) begin
      step();
      waited++;
    end
    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
